mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl_pkg.sv | 31 +++
 rtl/mdu_ctrl_alu.sv | 59 +++++
 rtl/mdu_ctrl.sv | 119 +++++++++++
 tb/tb_mdu_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_ctrl_pkg
// Description : Shared MD-unit encodings. This package holds the operation
//               codes, the FSM state type and the default latencies.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_ctrl_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Multi-cycle operations (MULT/MULTU/DIV/DIVU) occupy op codes 0..3.
    function automatic logic is_long_op(input logic [2:0] op);
        return ~op[2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_ctrl_alu.sv
`default_nettype none
// ============================================================================
// Module      : md_alu
// Description : Combinational multiply/divide datapath. It produces the
//               {HI,LO} result of a MULT/MULTU/DIV/DIVU operation.
// Revision    : 1.0 - initial release
// ============================================================================
module md_alu
    import mdu_ctrl_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] res,
    output logic        div_zero
);

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_sgn;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_dvsr;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    // The low 64 bits of a product of sign-extended operands form the signed product.
    assign w_prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign w_prod_u = {32'd0, a} * {32'd0, b};

    // A single unsigned divider works on magnitudes, and the signs are restored afterwards.
    assign w_sgn   = (op == OP_DIV);
    assign w_neg_a = w_sgn & a[31];
    assign w_neg_b = w_sgn & b[31];
    assign w_mag_a = w_neg_a ? (32'd0 - a) : a;
    assign w_mag_b = w_neg_b ? (32'd0 - b) : b;
    assign w_dvsr  = (w_mag_b == 32'd0) ? 32'd1 : w_mag_b;
    assign w_quo   = w_mag_a / w_dvsr;
    assign w_rem   = w_mag_a % w_dvsr;

    always_comb begin
        res      = '0;
        div_zero = 1'b0;
        case (op)
            OP_MULT:  res = w_prod_s;
            OP_MULTU: res = w_prod_u;
            OP_DIV, OP_DIVU: begin
                res[63:32] = w_neg_a ? (32'd0 - w_rem) : w_rem;
                res[31:0]  = (w_neg_a ^ w_neg_b) ? (32'd0 - w_quo) : w_quo;
                div_zero   = (b == 32'd0);
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mdu_ctrl
// Description : MD-unit controller. It contains the IDLE/BUSY FSM, the busy
//               counter, the pending result and the HI/LO registers.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        D_isMD,
    input  logic        IntReq,
    output logic        busy,
    output logic        D_md_stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               busy_q,  busy_d;
    logic [31:0]        hi_q,    hi_d;
    logic [31:0]        lo_q,    lo_d;
    logic [63:0]        pend_q,  pend_d;

    logic [63:0]        w_res;
    logic               w_div_zero;
    logic               w_accept;

    md_alu u_md_alu (
        .op       (op),
        .a        (A),
        .b        (B),
        .res      (w_res),
        .div_zero (w_div_zero)
    );

    assign w_accept = start & ~IntReq & (state_q == ST_IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        pend_d  = pend_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            pend_d  = w_res;
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            state_d = ST_BUSY;
                            busy_d  = 1'b1;
                        end
                        OP_DIV, OP_DIVU: begin
                            // A zero divisor recommits the current HI/LO, so they stay unchanged.
                            pend_d  = w_div_zero ? {hi_q, lo_q} : w_res;
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            state_d = ST_BUSY;
                            busy_d  = 1'b1;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = pend_q[63:32];
                    lo_d    = pend_q[31:0];
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            pend_q  <= pend_d;
        end
    end

    assign busy       = busy_q;
    assign HI         = hi_q;
    assign LO         = lo_q;
    assign D_md_stall = D_isMD & (busy_q | (start & is_long_op(op)));

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_ctrl
// Description : Self-checking bench for mdu_ctrl. It runs directed and
//               random stimulus against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        D_isMD = 1'b0;
    logic        IntReq = 1'b0;
    logic        busy;
    logic        D_md_stall;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .A          (A),
        .B          (B),
        .D_isMD     (D_isMD),
        .IntReq     (IntReq),
        .busy       (busy),
        .D_md_stall (D_md_stall),
        .HI         (HI),
        .LO         (LO)
    );

    always #5 clk = ~clk;

    // Architectural result of an MD operation, computed with wide integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a, b, hi, lo);
        longint sa, sb, q, r;
        logic [63:0] u, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd0: begin q = sa * sb; return q; end
            3'd1: begin u = {32'd0, a} * {32'd0, b}; return u; end
            3'd2: begin
                if (b == 32'd0) return {hi, lo};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'd3: begin
                if (b == 32'd0) return {hi, lo};
                uq = {32'd0, a} / {32'd0, b};
                ur = {32'd0, a} % {32'd0, b};
                return {ur[31:0], uq[31:0]};
            end
            default: return {hi, lo};
        endcase
    endfunction

    // Reference model: cycles remaining until the pending result lands in HI/LO.
    int          m_left;
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_pend;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left <= 0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_pend <= '0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_hi <= m_pend[63:32];
                m_lo <= m_pend[31:0];
            end
        end else if (start && !IntReq) begin
            if (op < 3'd2) begin
                m_left <= MULT_N;
                m_pend <= ref_result(op, A, B, m_hi, m_lo);
            end else if (op < 3'd4) begin
                m_left <= DIV_N;
                m_pend <= ref_result(op, A, B, m_hi, m_lo);
            end else if (op == 3'd4) begin
                m_hi <= A;
            end else if (op == 3'd5) begin
                m_lo <= A;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && !reset) begin
            check("cyc_busy", busy, (m_left > 0));
            check("cyc_hi", HI, m_hi);
            check("cyc_lo", LO, m_lo);
            check("cyc_stall", D_md_stall, D_isMD && ((m_left > 0) || (start && op < 3'd4)));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        step();
        start = 1'b0;
    endtask

    // Counts busy cycles and confirms that HI/LO hold their old values meanwhile.
    task automatic run_busy(input logic [31:0] hold_hi, input logic [31:0] hold_lo, output int n);
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            check("hold_hi", HI, hold_hi);
            check("hold_lo", LO, hold_lo);
            n++;
            step();
        end
    endtask

    initial begin
        int n;
        repeat (3) step();
        check("rst_busy", busy, 0);
        check("rst_hi", HI, 0);
        check("rst_lo", LO, 0);
        reset  = 1'b0;
        chk_en = 1'b1;

        issue(3'd0, 32'hFFFF_FFFE, 32'd3);
        run_busy(32'd0, 32'd0, n);
        check("mult_cycles", n, MULT_N);
        check("mult_hi", HI, 32'hFFFF_FFFF);
        check("mult_lo", LO, 32'hFFFF_FFFA);

        D_isMD = 1'b1;
        issue(3'd3, 32'd100, 32'd7);
        check("stall_busy", D_md_stall, 1);
        D_isMD = 1'b0;
        #1;
        check("stall_nomd", D_md_stall, 0);
        D_isMD = 1'b1;
        run_busy(32'hFFFF_FFFF, 32'hFFFF_FFFA, n);
        D_isMD = 1'b0;
        check("divu_cycles", n, DIV_N);
        check("divu_hi", HI, 32'd2);
        check("divu_lo", LO, 32'd14);

        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        run_busy(32'd2, 32'd14, n);
        check("div_hi", HI, 32'hFFFF_FFFF);
        check("div_lo", LO, 32'hFFFF_FFFD);

        issue(3'd2, 32'd55, 32'd0);
        run_busy(32'hFFFF_FFFF, 32'hFFFF_FFFD, n);
        check("div0_cycles", n, DIV_N);
        check("div0_hi", HI, 32'hFFFF_FFFF);
        check("div0_lo", LO, 32'hFFFF_FFFD);

        issue(3'd5, 32'h0000_1234, 32'd0);
        check("mtlo_lo", LO, 32'h0000_1234);
        check("mtlo_busy", busy, 0);

        IntReq = 1'b1;
        issue(3'd0, 32'd5, 32'd5);
        IntReq = 1'b0;
        check("intreq_busy", busy, 0);
        check("intreq_lo", LO, 32'h0000_1234);

        issue(3'd0, 32'd7, 32'd9);
        step();
        IntReq = 1'b1;
        step();
        IntReq = 1'b0;
        run_busy(32'hFFFF_FFFF, 32'h0000_1234, n);
        check("int_busy_left", n, MULT_N - 2);
        check("int_busy_hi", HI, 32'd0);
        check("int_busy_lo", LO, 32'd63);

        issue(3'd0, 32'd2, 32'd3);
        step();
        step();
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_hi", HI, 0);
        check("arst_lo", LO, 0);
        step();
        reset = 1'b0;
        issue(3'd0, 32'd6, 32'd7);
        run_busy(32'd0, 32'd0, n);
        check("post_rst_cycles", n, MULT_N);
        check("post_rst_lo", LO, 32'd42);

        for (int i = 0; i < 600; i++) begin
            start  = ($urandom_range(0, 2) == 0);
            op     = 3'($urandom_range(0, 7));
            A      = $urandom;
            B      = ($urandom_range(0, 7) == 0) ? 32'd0 :
                     (($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(1, 20)));
            IntReq = ($urandom_range(0, 7) == 0);
            D_isMD = ($urandom_range(0, 1) == 1);
            step();
        end
        start  = 1'b0;
        IntReq = 1'b0;
        D_isMD = 1'b0;
        repeat (DIV_N + 4) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
